ex_mem_skid_reg: RTL and testbench
==================================

Name: ex_mem_skid_reg

Overview:
Parametrised successor to the fixed EX/MEM pipeline register. It carries the EX-stage result bundle (control bits, ALU result, store data, destination register) to MEM using a valid/ready handshake. A two-entry skid buffer sustains 1 transfer/cycle under back-pressure. Adds synchronous flush (bubble insertion), a forwarding tap for the hazard unit, and a saturating stall counter.

Parameters:
XLEN, 64, width of AluResult/Datain and their outputs
REG_ADDR_W, 5, width of register index fields
STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous flush; discards all held entries
in_valid  in  1  EX presents a valid bundle
in_ready  out  1  register can accept a bundle this cycle
RegWrite  in  1  control: write register file
MemtoReg  in  1  control: writeback selects memory data
MemWrite  in  1  control: store
MemRead  in  1  control: load
AluResult  in  XLEN  ALU result / address
Datain  in  XLEN  store data
Rd_in  in  REG_ADDR_W  destination register
out_valid  out  1  MEM-side bundle valid
out_ready  in  1  MEM accepts bundle
RegWrite_Out, MemtoReg_Out, MemWrite_Out, MemRead_out  out  1 each  registered control, forced 0 when out_valid=0
AluOut  out  XLEN  registered ALU result
DataOut  out  XLEN  registered store data
Rd_out  out  REG_ADDR_W  registered destination
fwd_valid  out  1  out_valid & RegWrite_Out & (Rd_out != 0)
fwd_rd  out  REG_ADDR_W  equals Rd_out
fwd_data  out  XLEN  equals AluOut
stall_cnt  out  STALL_CNT_W  cycles with out_valid & !out_ready, saturating

Behaviour:
- Reset (async, active-high): state EMPTY; all outputs 0, including data fields and stall_cnt. in_ready is forced 0 while reset is high and becomes 1 on the first cycle after release.
- Two storage entries: main (drives outputs) and skid.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- FSM states and transitions:
  - EMPTY (out_valid=0, in_ready=1): in_fire -> BUSY, main loads the input.
  - BUSY (out_valid=1, in_ready=1):
    - in_fire & out_fire -> BUSY, main loads the input.
    - out_fire only -> EMPTY.
    - in_fire only -> FULL, skid loads the input.
    - neither -> BUSY, hold.
  - FULL (out_valid=1, in_ready=0): out_fire -> BUSY, main <= skid. Otherwise hold.
- in_ready is a function of registered state only; there is no combinational path from out_ready.
- Latency: 1 cycle from in_fire (state EMPTY) to out_valid. Throughput is 1 bundle/cycle when out_ready is held high.
- Flush: from any state -> EMPTY next cycle. Both entries are invalidated and control outputs read 0. Flush has priority over a simultaneous in_fire (that bundle is dropped) and over out_fire. Data fields may keep stale values.
- Bubble safety: any invalid entry presents all four control outputs as 0, so MEM never stores or writes back from a bubble.
- stall_cnt increments each cycle out_valid & !out_ready and saturates at all-ones. It is cleared only by reset; flush does not affect it.
- Data fields are captured at full XLEN; there is no truncation or extension.
- Reset asserted mid-operation: state and outputs clear immediately, without waiting for a clock edge.

Decomposition:
- Package pipe_pkg:
  - ex_mem_ctrl_t packed struct {RegWrite, MemtoReg, MemWrite, MemRead}
  - skid_state_t enum {EMPTY, BUSY, FULL}
  - localparam CTRL_W = 4
- One sub-module, pipe_skid_buf, parametrised by payload width W. It holds the FSM, both entries and the handshake. The top module packs ctrl/AluResult/Datain/Rd_in into the payload, applies flush, gates control on valid, and adds the forwarding tap and stall counter.

Test Plan:
1. Reset held 3 cycles with random inputs -> all outputs 0, in_ready=0. One cycle after release, in_ready=1.
2. out_ready=1; present AluResult=64'hDEAD_BEEF_0000_0001, Datain=64'h1234, Rd_in=5'd7, RegWrite=1 -> next cycle out_valid=1, AluOut/DataOut/Rd_out match, fwd_valid=1, fwd_rd=7.
3. out_ready=0; push bundles A then B -> state FULL, in_ready=0, outputs show A, stall_cnt increments each cycle. Raise out_ready -> A then B appear on consecutive cycles with nothing lost or duplicated.
4. FULL with MemWrite=1 entries; assert flush together with in_valid=1 -> next cycle out_valid=0, MemWrite_Out=0, in_ready=1, and the flushed input never appears.
5. Rd_in=0 with RegWrite=1 -> out_valid=1, RegWrite_Out=1, fwd_valid=0.
6. STALL_CNT_W=4; hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 4'hF. Then assert reset mid-stall -> stall_cnt=0 and out_valid=0 immediately.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the EX/MEM pipeline register: control bundle and skid-buffer state encoding.
// No logic here; latency and backpressure belong to the modules that import it.
package pipe_pkg;

    localparam int CTRL_W = 4;

    typedef struct packed {
        logic reg_write;
        logic memto_reg;
        logic mem_write;
        logic mem_read;
    } ex_mem_ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer carrying a W-bit payload over valid/ready, 1-cycle latency.
// in_ready depends only on registered state, so 1 transfer/cycle survives a stalled consumer.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         live;
    logic         in_fire;
    logic         out_fire;

    // live keeps in_ready low during reset and until the first edge after release
    assign in_ready  = live && (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
            live   <= 1'b0;
        end else begin
            live <= 1'b1;
            if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (in_fire) begin
                            main_q <= in_data;
                            state  <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (in_fire && out_fire) begin
                            main_q <= in_data;
                        end else if (out_fire) begin
                            state <= EMPTY;
                        end else if (in_fire) begin
                            skid_q <= in_data;
                            state  <= FULL;
                        end
                    end
                    FULL: begin
                        if (out_fire) begin
                            main_q <= skid_q;
                            state  <= BUSY;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM register over a skid buffer with flush, bubble-safe control, forwarding tap, stall counter.
// 1-cycle latency, full throughput; in_ready drops only when both entries are held.
module ex_mem_skid_reg
    import pipe_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   RegWrite,
    input  logic                   MemtoReg,
    input  logic                   MemWrite,
    input  logic                   MemRead,
    input  logic [XLEN-1:0]        AluResult,
    input  logic [XLEN-1:0]        Datain,
    input  logic [REG_ADDR_W-1:0]  Rd_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   RegWrite_Out,
    output logic                   MemtoReg_Out,
    output logic                   MemWrite_Out,
    output logic                   MemRead_out,
    output logic [XLEN-1:0]        AluOut,
    output logic [XLEN-1:0]        DataOut,
    output logic [REG_ADDR_W-1:0]  Rd_out,
    output logic                   fwd_valid,
    output logic [REG_ADDR_W-1:0]  fwd_rd,
    output logic [XLEN-1:0]        fwd_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int PAY_W = CTRL_W + 2 * XLEN + REG_ADDR_W;

    typedef struct packed {
        ex_mem_ctrl_t          ctrl;
        logic [XLEN-1:0]       alu;
        logic [XLEN-1:0]       data;
        logic [REG_ADDR_W-1:0] rd;
    } payload_t;

    payload_t     pay_in;
    payload_t     pay_out;
    ex_mem_ctrl_t ctrl_vis;

    assign pay_in.ctrl = '{reg_write: RegWrite, memto_reg: MemtoReg,
                           mem_write: MemWrite, mem_read: MemRead};
    assign pay_in.alu  = AluResult;
    assign pay_in.data = Datain;
    assign pay_in.rd   = Rd_in;

    pipe_skid_buf #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out)
    );

    // A bubble must never store or write back, whatever stale bits the entry holds
    assign ctrl_vis     = out_valid ? pay_out.ctrl : '0;
    assign RegWrite_Out = ctrl_vis.reg_write;
    assign MemtoReg_Out = ctrl_vis.memto_reg;
    assign MemWrite_Out = ctrl_vis.mem_write;
    assign MemRead_out  = ctrl_vis.mem_read;
    assign AluOut       = pay_out.alu;
    assign DataOut      = pay_out.data;
    assign Rd_out       = pay_out.rd;

    assign fwd_valid = out_valid && RegWrite_Out && (Rd_out != '0);
    assign fwd_rd    = Rd_out;
    assign fwd_data  = AluOut;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Scenario bench for ex_mem_skid_reg: queue scoreboard plus per-scenario directed checks.
module tb_ex_mem_skid_reg;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic        RegWrite, MemtoReg, MemWrite, MemRead;
    logic        RegWrite_Out, MemtoReg_Out, MemWrite_Out, MemRead_out;
    logic [63:0] AluResult, Datain, AluOut, DataOut, fwd_data;
    logic [4:0]  Rd_in, Rd_out, fwd_rd;
    logic        fwd_valid;
    logic [3:0]  stall_cnt;

    ex_mem_skid_reg #(.XLEN(64), .REG_ADDR_W(5), .STALL_CNT_W(4)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .MemRead(MemRead),
        .AluResult(AluResult), .Datain(Datain), .Rd_in(Rd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .RegWrite_Out(RegWrite_Out), .MemtoReg_Out(MemtoReg_Out),
        .MemWrite_Out(MemWrite_Out), .MemRead_out(MemRead_out),
        .AluOut(AluOut), .DataOut(DataOut), .Rd_out(Rd_out),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [63:0] alu;
        logic [63:0] din;
        logic [4:0]  rd;
    } bundle_t;

    bundle_t     q[$];
    bundle_t     head;
    int unsigned cnt_m = 0;
    bit          rdy_m = 1'b0;
    bit          exp_v, exp_r;
    int          vec = 0;
    int          miss = 0;

    // Scoreboard: samples 2 time units before each rising edge, then advances the model
    always @(negedge clk) begin
        #3;
        if (reset) begin
            vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || stall_cnt !== 4'd0) begin
                miss++;
                $display("FAIL mon_reset: out_valid=%b in_ready=%b stall_cnt=%0d want 0 0 0",
                         out_valid, in_ready, stall_cnt);
            end
            q.delete();
            cnt_m = 0;
            rdy_m = 1'b0;
        end else begin
            exp_v = (q.size() != 0);
            exp_r = rdy_m && (q.size() < 2);
            vec++;
            if (out_valid !== exp_v || in_ready !== exp_r) begin
                miss++;
                $display("FAIL mon_handshake: out_valid=%b in_ready=%b want %b %b",
                         out_valid, in_ready, exp_v, exp_r);
            end
            vec++;
            if (stall_cnt !== cnt_m[3:0]) begin
                miss++;
                $display("FAIL mon_stall_cnt: got %0d want %0d", stall_cnt, cnt_m);
            end
            vec++;
            if (exp_v) begin
                head = q[0];
                if ({RegWrite_Out, MemtoReg_Out, MemWrite_Out, MemRead_out} !== head.ctrl ||
                    AluOut !== head.alu || DataOut !== head.din || Rd_out !== head.rd ||
                    fwd_valid !== (head.ctrl[3] && head.rd != 5'd0) ||
                    fwd_rd !== head.rd || fwd_data !== head.alu) begin
                    miss++;
                    $display("FAIL mon_data: ctrl=%b alu=%h din=%h rd=%0d fwd=%b want ctrl=%b alu=%h din=%h rd=%0d",
                             {RegWrite_Out, MemtoReg_Out, MemWrite_Out, MemRead_out}, AluOut, DataOut,
                             Rd_out, fwd_valid, head.ctrl, head.alu, head.din, head.rd);
                end
            end else begin
                if ({RegWrite_Out, MemtoReg_Out, MemWrite_Out, MemRead_out} !== 4'b0 || fwd_valid !== 1'b0) begin
                    miss++;
                    $display("FAIL mon_bubble: ctrl=%b fwd_valid=%b want 0000 0",
                             {RegWrite_Out, MemtoReg_Out, MemWrite_Out, MemRead_out}, fwd_valid);
                end
            end
            if (exp_v && !out_ready && cnt_m < 15) cnt_m++;
            if (flush) begin
                q.delete();
            end else begin
                if (exp_v && out_ready) void'(q.pop_front());
                if (in_valid && exp_r)
                    q.push_back({RegWrite, MemtoReg, MemWrite, MemRead, AluResult, Datain, Rd_in});
            end
            rdy_m = 1'b1;
        end
    end

    task automatic set_in(input logic v, input logic [3:0] c, input logic [63:0] a,
                          input logic [63:0] d, input logic [4:0] r);
        in_valid = v;
        {RegWrite, MemtoReg, MemWrite, MemRead} = c;
        AluResult = a;
        Datain = d;
        Rd_in = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; flush = 1'b0; set_in(1'b0, 4'b0, 64'd0, 64'd0, 5'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(1'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
            out_ready = 1'($urandom);
            #1;
            vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || AluOut !== 64'd0 || DataOut !== 64'd0 ||
                Rd_out !== 5'd0 || stall_cnt !== 4'd0 || fwd_valid !== 1'b0 ||
                {RegWrite_Out, MemtoReg_Out, MemWrite_Out, MemRead_out} !== 4'b0) begin
                miss++;
                $display("FAIL reset_outputs: out_valid=%b in_ready=%b alu=%h din=%h rd=%0d cnt=%0d want all 0",
                         out_valid, in_ready, AluOut, DataOut, Rd_out, stall_cnt);
            end
        end
        @(negedge clk);
        reset = 1'b0; set_in(1'b0, 4'b0, 64'd0, 64'd0, 5'd0); out_ready = 1'b1;
        #1;
        vec++;
        if (in_ready !== 1'b0) begin
            miss++; $display("FAIL reset_release_ready: in_ready=%b want 0", in_ready);
        end
        @(negedge clk); #1;
        vec++;
        if (in_ready !== 1'b1) begin
            miss++; $display("FAIL reset_ready_after: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        out_ready = 1'b1;
        set_in(1'b1, 4'b1000, 64'hDEAD_BEEF_0000_0001, 64'h1234, 5'd7);
        @(negedge clk);
        set_in(1'b0, 4'b0, 64'd0, 64'd0, 5'd0);
        #1;
        vec++;
        if (out_valid !== 1'b1 || AluOut !== 64'hDEAD_BEEF_0000_0001 || DataOut !== 64'h1234 ||
            Rd_out !== 5'd7 || fwd_valid !== 1'b1 || fwd_rd !== 5'd7 || RegWrite_Out !== 1'b1) begin
            miss++;
            $display("FAIL basic_latency: v=%b alu=%h din=%h rd=%0d fwd=%b/%0d want 1 deadbeef00000001 1234 7 1/7",
                     out_valid, AluOut, DataOut, Rd_out, fwd_valid, fwd_rd);
        end
        @(negedge clk); #1;
        vec++;
        if (out_valid !== 1'b0) begin
            miss++; $display("FAIL basic_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_rd_zero();
        @(negedge clk);
        out_ready = 1'b1;
        set_in(1'b1, 4'b1000, 64'h55, 64'h66, 5'd0);
        @(negedge clk);
        set_in(1'b0, 4'b0, 64'd0, 64'd0, 5'd0);
        #1;
        vec++;
        if (out_valid !== 1'b1 || RegWrite_Out !== 1'b1 || fwd_valid !== 1'b0) begin
            miss++;
            $display("FAIL rd_zero_fwd: v=%b rw=%b fwd_valid=%b want 1 1 0", out_valid, RegWrite_Out, fwd_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_in(1'b1, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
            #1;
            vec++;
            if (in_ready !== 1'b1 || (i > 0 && out_valid !== 1'b1)) begin
                miss++; $display("FAIL b2b_stream: i=%0d in_ready=%b out_valid=%b want 1 1", i, in_ready, out_valid);
            end
        end
        @(negedge clk);
        set_in(1'b0, 4'b0, 64'd0, 64'd0, 5'd0);
        @(negedge clk); #1;
        vec++;
        if (out_valid !== 1'b0) begin
            miss++; $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        set_in(1'b1, 4'b0100, 64'hA, 64'hA0, 5'd1);
        @(negedge clk);
        set_in(1'b1, 4'b0001, 64'hB, 64'hB0, 5'd2);
        #1;
        vec++;
        if (out_valid !== 1'b1 || AluOut !== 64'hA || stall_cnt !== 4'd0 || in_ready !== 1'b1) begin
            miss++; $display("FAIL bp_first: v=%b alu=%h cnt=%0d rdy=%b want 1 a 0 1", out_valid, AluOut, stall_cnt, in_ready);
        end
        @(negedge clk);
        set_in(1'b0, 4'b0, 64'd0, 64'd0, 5'd0);
        #1;
        vec++;
        if (in_ready !== 1'b0 || AluOut !== 64'hA || stall_cnt !== 4'd1) begin
            miss++; $display("FAIL bp_full: rdy=%b alu=%h cnt=%0d want 0 a 1", in_ready, AluOut, stall_cnt);
        end
        @(negedge clk); #1;
        vec++;
        if (stall_cnt !== 4'd2 || AluOut !== 64'hA) begin
            miss++; $display("FAIL bp_hold: cnt=%0d alu=%h want 2 a", stall_cnt, AluOut);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        vec++;
        if (stall_cnt !== 4'd3 || AluOut !== 64'hA) begin
            miss++; $display("FAIL bp_release: cnt=%0d alu=%h want 3 a", stall_cnt, AluOut);
        end
        @(negedge clk); #1;
        vec++;
        if (out_valid !== 1'b1 || AluOut !== 64'hB || DataOut !== 64'hB0 || in_ready !== 1'b1 || stall_cnt !== 4'd3) begin
            miss++; $display("FAIL bp_second: v=%b alu=%h din=%h rdy=%b cnt=%0d want 1 b b0 1 3",
                             out_valid, AluOut, DataOut, in_ready, stall_cnt);
        end
        @(negedge clk); #1;
        vec++;
        if (out_valid !== 1'b0) begin
            miss++; $display("FAIL bp_empty: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b0;
        set_in(1'b1, 4'b0010, 64'hC, 64'hC0, 5'd3);
        @(negedge clk);
        set_in(1'b1, 4'b0010, 64'hD, 64'hD0, 5'd4);
        @(negedge clk);
        flush = 1'b1;
        set_in(1'b1, 4'b1010, 64'hE, 64'hE0, 5'd5);
        #1;
        vec++;
        if (MemWrite_Out !== 1'b1 || in_ready !== 1'b0 || stall_cnt !== 4'd4) begin
            miss++; $display("FAIL flush_pre: mw=%b rdy=%b cnt=%0d want 1 0 4", MemWrite_Out, in_ready, stall_cnt);
        end
        @(negedge clk);
        flush = 1'b0;
        set_in(1'b0, 4'b0, 64'd0, 64'd0, 5'd0);
        #1;
        vec++;
        if (out_valid !== 1'b0 || MemWrite_Out !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 4'd5) begin
            miss++; $display("FAIL flush_full: v=%b mw=%b rdy=%b cnt=%0d want 0 0 1 5",
                             out_valid, MemWrite_Out, in_ready, stall_cnt);
        end
        @(negedge clk);
        set_in(1'b1, 4'b0010, 64'hF, 64'hF0, 5'd6);
        @(negedge clk);
        flush = 1'b1;
        set_in(1'b1, 4'b1000, 64'h77, 64'h70, 5'd7);
        #1;
        vec++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || AluOut !== 64'hF) begin
            miss++; $display("FAIL flush_busy_pre: v=%b rdy=%b alu=%h want 1 1 f", out_valid, in_ready, AluOut);
        end
        @(negedge clk);
        flush = 1'b0;
        set_in(1'b0, 4'b0, 64'd0, 64'd0, 5'd0);
        #1;
        vec++;
        if (out_valid !== 1'b0 || stall_cnt !== 4'd6) begin
            miss++; $display("FAIL flush_busy: v=%b cnt=%0d want 0 6", out_valid, stall_cnt);
        end
        @(negedge clk); #1;
        vec++;
        if (out_valid !== 1'b0) begin
            miss++; $display("FAIL flush_dropped: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            out_ready = ($urandom_range(3) != 0);
            flush = ($urandom_range(15) == 0);
            set_in(1'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
        end
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b1;
        set_in(1'b0, 4'b0, 64'd0, 64'd0, 5'd0);
        @(negedge clk);
        @(negedge clk); #1;
        vec++;
        if (out_valid !== 1'b0 || q.size() != 0) begin
            miss++; $display("FAIL random_drain: out_valid=%b pending=%0d want 0 0", out_valid, q.size());
        end
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready = 1'b0;
        set_in(1'b1, 4'b1000, 64'h1, 64'h2, 5'd3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            set_in(1'b0, 4'b0, 64'd0, 64'd0, 5'd0);
            #1;
            if (i == 14) begin
                vec++;
                if (stall_cnt !== 4'hE) begin
                    miss++; $display("FAIL sat_pre: cnt=%0d want 14", stall_cnt);
                end
            end
        end
        vec++;
        if (stall_cnt !== 4'hF || out_valid !== 1'b1) begin
            miss++; $display("FAIL sat_hold: cnt=%0d v=%b want 15 1", stall_cnt, out_valid);
        end
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        vec++;
        if (stall_cnt !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || AluOut !== 64'd0) begin
            miss++; $display("FAIL sat_async_reset: cnt=%0d v=%b rdy=%b alu=%h want 0 0 0 0",
                             stall_cnt, out_valid, in_ready, AluOut);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 4'b0, 64'd0, 64'd0, 5'd0);
        test_reset();
        test_basic();
        test_rd_zero();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
